// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting sequencer for the clock.
// Ports: CLK, RST (sync, active-high), TICK_MS (1 kHz strobe),
//   MODE/UP/DN _FLAG (debounced edge) and _STATE (0 = pressed),
//   FIELD (0 run, 1 h, 2 m, 3 s), SET_MODE, INC, DEC, BLINK.
`timescale 1ns/1ps
module clock_set_ctrl #(
    parameter int LONG_MS    = 800,
    parameter int REPEAT_MS  = 150,
    parameter int TIMEOUT_MS = 8000,
    parameter int BLINK_MS   = 250
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK_MS,
    input  logic       MODE_FLAG,
    input  logic       MODE_STATE,
    input  logic       UP_FLAG,
    input  logic       UP_STATE,
    input  logic       DN_FLAG,
    input  logic       DN_STATE,
    output logic [1:0] FIELD,
    output logic       SET_MODE,
    output logic       INC,
    output logic       DEC,
    output logic       BLINK
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_UP   = 2'd1,
        OWN_DN   = 2'd2
    } owner_t;

    localparam logic [13:0] LONG_C    = 14'(LONG_MS);
    localparam logic [13:0] RELOAD_C  = 14'(LONG_MS - REPEAT_MS);
    localparam logic [13:0] TIMEOUT_C = 14'(TIMEOUT_MS);
    localparam logic [13:0] BLINK_C   = 14'(BLINK_MS);

    state_t      state_q, state_n;
    owner_t      owner_q, owner_n;
    logic [13:0] hold_q, hold_n;
    logic [13:0] idle_q, idle_n;
    logic [13:0] bcnt_q, bcnt_n;
    logic        blink_q, blink_n;
    logic        set_q;
    logic        inc_q, inc_n;
    logic        dec_q, dec_n;

    logic mode_press;
    logic up_press, up_release;
    logic dn_press, dn_release;
    logic owner_release;

    assign mode_press = MODE_FLAG & ~MODE_STATE;
    assign up_press   = UP_FLAG & ~UP_STATE;
    assign up_release = UP_FLAG & UP_STATE;
    assign dn_press   = DN_FLAG & ~DN_STATE;
    assign dn_release = DN_FLAG & DN_STATE;

    assign owner_release = (owner_q == OWN_UP && up_release) ||
                           (owner_q == OWN_DN && dn_release);

    always_comb begin
        state_n = state_q;
        owner_n = owner_q;
        hold_n  = hold_q;
        idle_n  = idle_q;
        bcnt_n  = bcnt_q;
        blink_n = blink_q;
        inc_n   = 1'b0;
        dec_n   = 1'b0;

        if (state_q == RUN) begin
            if (mode_press) begin
                state_n = SET_H;
                blink_n = 1'b1;
                bcnt_n  = '0;
                idle_n  = '0;
            end
        end else if (mode_press) begin
            // Advancing the field drops any held key; it must be
            // pressed again before it adjusts the new field.
            state_n = (state_q == SET_S) ? RUN
                                         : state_t'(state_q + 2'd1);
            owner_n = OWN_NONE;
            hold_n  = '0;
            idle_n  = '0;
            bcnt_n  = '0;
            blink_n = (state_q != SET_S);
        end else begin
            if (owner_q == OWN_NONE) begin
                if (up_press) begin
                    owner_n = OWN_UP;
                    inc_n   = 1'b1;
                    hold_n  = '0;
                end else if (dn_press) begin
                    owner_n = OWN_DN;
                    dec_n   = 1'b1;
                    hold_n  = '0;
                end
            end else if (owner_release) begin
                owner_n = OWN_NONE;
                hold_n  = '0;
            end else if (TICK_MS) begin
                // Reload below threshold so later pulses come
                // every REPEAT_MS ticks.
                if (hold_q + 14'd1 == LONG_C) begin
                    hold_n = RELOAD_C;
                    inc_n  = (owner_q == OWN_UP);
                    dec_n  = (owner_q == OWN_DN);
                end else begin
                    hold_n = hold_q + 14'd1;
                end
            end

            if (owner_n != OWN_NONE) begin
                blink_n = 1'b1;
                bcnt_n  = '0;
            end else if (TICK_MS) begin
                if (bcnt_q + 14'd1 == BLINK_C) begin
                    blink_n = ~blink_q;
                    bcnt_n  = '0;
                end else begin
                    bcnt_n = bcnt_q + 14'd1;
                end
            end

            // Any press here also cancels a coincident timeout.
            if (up_press || dn_press || owner_q != OWN_NONE) begin
                idle_n = '0;
            end else if (TICK_MS) begin
                if (idle_q + 14'd1 == TIMEOUT_C) begin
                    state_n = RUN;
                    owner_n = OWN_NONE;
                    hold_n  = '0;
                    idle_n  = '0;
                    bcnt_n  = '0;
                    blink_n = 1'b0;
                end else begin
                    idle_n = idle_q + 14'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            owner_q <= OWN_NONE;
            hold_q  <= '0;
            idle_q  <= '0;
            bcnt_q  <= '0;
            blink_q <= 1'b0;
            set_q   <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            owner_q <= owner_n;
            hold_q  <= hold_n;
            idle_q  <= idle_n;
            bcnt_q  <= bcnt_n;
            blink_q <= blink_n;
            set_q   <= (state_n != RUN);
            inc_q   <= inc_n;
            dec_q   <= dec_n;
        end
    end

    assign FIELD    = state_q;
    assign SET_MODE = set_q;
    assign INC      = inc_q;
    assign DEC      = dec_q;
    assign BLINK    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed bench for clock_set_ctrl.
// Small timing parameters; expected values worked out by hand.
`timescale 1ns/1ps
module tb_clock_set_ctrl;

    logic       CLK;
    logic       RST;
    logic       TICK_MS;
    logic       MODE_FLAG, MODE_STATE;
    logic       UP_FLAG, UP_STATE;
    logic       DN_FLAG, DN_STATE;
    logic [1:0] FIELD;
    logic       SET_MODE, INC, DEC, BLINK;

    int tests = 0;
    int fails = 0;
    int inc_cnt = 0;
    int dec_cnt = 0;
    int inc_base, dec_base;

    clock_set_ctrl #(
        .LONG_MS(8), .REPEAT_MS(3), .TIMEOUT_MS(20), .BLINK_MS(2)
    ) dut (
        .CLK(CLK), .RST(RST), .TICK_MS(TICK_MS),
        .MODE_FLAG(MODE_FLAG), .MODE_STATE(MODE_STATE),
        .UP_FLAG(UP_FLAG), .UP_STATE(UP_STATE),
        .DN_FLAG(DN_FLAG), .DN_STATE(DN_STATE),
        .FIELD(FIELD), .SET_MODE(SET_MODE),
        .INC(INC), .DEC(DEC), .BLINK(BLINK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pulses are stable mid-cycle, so count them on the falling edge.
    always @(negedge CLK) begin
        if (INC) inc_cnt++;
        if (DEC) dec_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; strobes last exactly one cycle.
    task automatic clk1();
        @(posedge CLK);
        #1;
        TICK_MS = 1'b0;
        MODE_FLAG = 1'b0;
        UP_FLAG = 1'b0;
        DN_FLAG = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            TICK_MS = 1'b1;
            clk1();
        end
    endtask

    task automatic mode_step(input string tag, input int exp_field);
        MODE_FLAG = 1'b1; MODE_STATE = 1'b0;
        clk1();
        check({tag, "_field"}, FIELD, exp_field);
        check({tag, "_set"}, SET_MODE, int'(exp_field != 0));
        MODE_FLAG = 1'b1; MODE_STATE = 1'b1;
        clk1();
    endtask

    initial begin
        RST = 1'b1;
        TICK_MS = 1'b0;
        MODE_FLAG = 1'b0; MODE_STATE = 1'b1;
        UP_FLAG = 1'b0;   UP_STATE = 1'b1;
        DN_FLAG = 1'b0;   DN_STATE = 1'b1;
        clk1();
        clk1();
        RST = 1'b0;
        clk1();
        check("rst_field", FIELD, 0);
        check("rst_set", SET_MODE, 0);
        check("rst_inc", INC, 0);
        check("rst_dec", DEC, 0);
        check("rst_blink", BLINK, 0);

        // Mode sequencing
        mode_step("m1", 1);
        check("m1_blink", BLINK, 1);
        mode_step("m2", 2);
        mode_step("m3", 3);
        mode_step("m4", 0);
        check("m4_blink", BLINK, 0);
        inc_base = inc_cnt;
        UP_FLAG = 1'b1; UP_STATE = 1'b0;
        clk1();
        check("run_up_inc", INC, 0);
        UP_FLAG = 1'b1; UP_STATE = 1'b1;
        clk1();
        ticks(10);
        check("run_up_cnt", inc_cnt - inc_base, 0);

        // Short press on minutes
        mode_step("s1", 1);
        mode_step("s2", 2);
        inc_base = inc_cnt;
        dec_base = dec_cnt;
        UP_FLAG = 1'b1; UP_STATE = 1'b0;
        clk1();
        check("short_inc1", INC, 1);
        check("short_dec1", DEC, 0);
        clk1();
        check("short_inc2", INC, 0);
        ticks(3);
        check("short_blink", BLINK, 1);
        UP_FLAG = 1'b1; UP_STATE = 1'b1;
        clk1();
        ticks(10);
        check("short_cnt", inc_cnt - inc_base, 1);
        check("short_dcnt", dec_cnt - dec_base, 0);

        // Long press on hours: 2 -> 3 -> 0 -> 1
        mode_step("l1", 3);
        mode_step("l2", 0);
        mode_step("l3", 1);
        inc_base = inc_cnt;
        dec_base = dec_cnt;
        DN_FLAG = 1'b1; DN_STATE = 1'b0;
        clk1();
        check("long_dec0", DEC, 1);
        for (int k = 1; k <= 15; k++) begin
            TICK_MS = 1'b1;
            clk1();
            check($sformatf("long_t%0d", k), DEC,
                  int'(k == 8 || k == 11 || k == 14));
        end
        DN_FLAG = 1'b1; DN_STATE = 1'b1;
        clk1();
        ticks(10);
        check("long_dcnt", dec_cnt - dec_base, 4);
        check("long_icnt", inc_cnt - inc_base, 0);

        // Contention
        inc_base = inc_cnt;
        dec_base = dec_cnt;
        UP_FLAG = 1'b1; UP_STATE = 1'b0;
        DN_FLAG = 1'b1; DN_STATE = 1'b0;
        clk1();
        check("both_inc", INC, 1);
        check("both_dec", DEC, 0);
        DN_FLAG = 1'b1; DN_STATE = 1'b1;
        clk1();
        DN_FLAG = 1'b1; DN_STATE = 1'b0;
        clk1();
        check("own_dec", DEC, 0);
        UP_FLAG = 1'b1; UP_STATE = 1'b1;
        clk1();
        check("own_rel_dec", DEC, 0);
        DN_FLAG = 1'b1; DN_STATE = 1'b1;
        clk1();
        DN_FLAG = 1'b1; DN_STATE = 1'b0;
        clk1();
        check("dn_after", DEC, 1);
        DN_FLAG = 1'b1; DN_STATE = 1'b1;
        clk1();
        check("cont_icnt", inc_cnt - inc_base, 1);
        check("cont_dcnt", dec_cnt - dec_base, 1);

        // Timeout on seconds
        mode_step("t1", 2);
        mode_step("t2", 3);
        ticks(2);
        check("blink_tog", BLINK, 0);
        ticks(17);
        check("to_t19", FIELD, 3);
        ticks(1);
        check("to_t20", FIELD, 0);
        check("to_set", SET_MODE, 0);
        check("to_blink", BLINK, 0);

        // Press on tick 19 cancels the timeout
        mode_step("c1", 1);
        mode_step("c2", 2);
        mode_step("c3", 3);
        ticks(18);
        TICK_MS = 1'b1;
        UP_FLAG = 1'b1; UP_STATE = 1'b0;
        clk1();
        check("c_inc", INC, 1);
        ticks(1);
        check("c_t20", FIELD, 3);
        UP_FLAG = 1'b1; UP_STATE = 1'b1;
        clk1();
        check("c_rel", FIELD, 3);

        // Reset mid-repeat
        inc_base = inc_cnt;
        UP_FLAG = 1'b1; UP_STATE = 1'b0;
        clk1();
        ticks(10);
        check("r_cnt", inc_cnt - inc_base, 2);
        RST = 1'b1;
        TICK_MS = 1'b1;
        clk1();
        RST = 1'b0;
        check("r_field", FIELD, 0);
        check("r_set", SET_MODE, 0);
        check("r_inc", INC, 0);
        check("r_dec", DEC, 0);
        check("r_blink", BLINK, 0);
        ticks(10);
        check("r_after", inc_cnt - inc_base, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the clock. Consumes debounced event pairs (FLAG, STATE) from three key debouncers (MODE, UP, DOWN) and sequences the clock through run and set modes. It emits single-cycle INC/DEC commands for the selected time field, with long-press auto-repeat and an idle timeout. It sits between the key debouncers and the hour/minute/second counters, and drives the display blink control.

## Interface
- LONG_MS, 800: hold time in ms before auto-repeat starts.
- REPEAT_MS, 150: auto-repeat period in ms.
- TIMEOUT_MS, 8000: idle time in ms in a set state before the controller returns to RUN. Must be at most 16383.
- BLINK_MS, 250: blink half-period in ms.

- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- TICK_MS  in  1  one-cycle strobe at 1 kHz from the shared divider.
- MODE_FLAG, UP_FLAG, DN_FLAG  in  1 each  one-cycle debounced-edge strobe.
- MODE_STATE, UP_STATE, DN_STATE  in  1 each  debounced level; 0 = pressed, 1 = released.
- FIELD  out  2  0 = run, 1 = hour, 2 = minute, 3 = second.
- SET_MODE  out  1  high whenever FIELD != 0.
- INC  out  1  one-cycle increment command for FIELD.
- DEC  out  1  one-cycle decrement command for FIELD.
- BLINK  out  1  blank-enable for the selected field; 0 in RUN.

## Operation
- Event decode:
  - press = FLAG & ~STATE.
  - release = FLAG & STATE.
- FSM states: RUN, SET_H, SET_M, SET_S. On MODE press:
  - RUN → SET_H → SET_M → SET_S → RUN.
  - FIELD and SET_MODE are registered from the FSM state.
- UP and DN key handling:
  - In RUN, UP/DN events are ignored.
  - In a set state, an UP press with no current owner makes UP the owner and pulses INC. A DN press likewise makes DN the owner and pulses DEC.
  - If UP and DN press in the same cycle, UP wins; the DN press is discarded.
  - While an owner exists, press events from the other key are ignored. The other key does not become owner when the owner is released.
  - Owner release clears the owner, the hold counter and the repeat state.
- Auto-repeat:
  - A 14-bit hold counter counts TICK_MS while the owner is held.
  - When the counter reaches LONG_MS, emit one pulse (INC for UP, DEC for DN) and reload the counter to LONG_MS−REPEAT_MS. Pulses therefore occur at LONG_MS, LONG_MS+REPEAT_MS, … ticks after the press.
- MODE press while an owner is held:
  - The field advances and the owner is cleared.
  - No further pulses until a new press.
- Idle timeout:
  - A 14-bit counter increments on TICK_MS in set states while no owner exists.
  - It clears on any press event (MODE, UP or DN) and while an owner exists.
  - On reaching TIMEOUT_MS: FSM → RUN, FIELD = 0, counters cleared.
- BLINK:
  - Set to 1 on entry to any set state, including field advance.
  - Toggles every BLINK_MS ticks; the blink counter restarts on each entry.
  - Forced to 1 while an owner is held, so the value stays visible during adjust.
  - 0 in RUN.
- INC and DEC are never high in the same cycle, and never high in RUN.

## Timing
- Reset values: FIELD = 0, SET_MODE = 0, INC = 0, DEC = 0, BLINK = 0. FSM = RUN, owner = none, all counters 0.
- RST has priority over all inputs. Reset mid-repeat kills pulses in the following cycle.
- MODE press in cycle N → FIELD/SET_MODE updated at N+1.
- UP/DN press in cycle N → INC/DEC high for exactly cycle N+1.
- Repeat pulse: high in the cycle after the TICK_MS that brings the hold count to threshold.
- Timeout: FIELD = 0 in the cycle after the TICK_MS that reaches TIMEOUT_MS.
- A press event in the same cycle as the timeout tick takes priority; the timeout is cancelled.
- A FLAG without TICK_MS is processed the same cycle. TICK_MS and FLAG may coincide.

## Test plan
Bench parameters: LONG_MS=8, REPEAT_MS=3, TIMEOUT_MS=20, BLINK_MS=2.
- Mode sequencing: reset, then 4 MODE presses → FIELD 1, 2, 3, 0, each one cycle after its press. SET_MODE tracks FIELD != 0. UP press in RUN → no INC.
- Short press: FIELD=2, UP press then release after 3 ticks → exactly one INC pulse, one cycle after the press.
- Long press: FIELD=1, DN held for 15 ticks → DEC at press+1 cycle, then after ticks 8, 11 and 14. Total 4 pulses; none after release.
- Contention: UP and DN press in the same cycle → INC only. UP held, then DN press → no DEC. UP release then DN press → one DEC.
- Timeout: FIELD=3, no keys for 20 ticks → FIELD=0 after tick 20. Repeat with an UP press at tick 19 → FIELD stays 3.
- Reset mid-repeat: UP held past 8 ticks, assert RST for one cycle → all outputs 0 next cycle, no further INC pulses.
